digest_serializer: RTL and testbench

Downstream consumer of the Blake2 hash engine, alongside the block controller. It captures the 512-bit digest when the engine raises digest_valid. It then returns the digest to the processor as BUS_WIDTH-wide words over a valid/ready handshake. It also flags digests that arrive while a readout is still in progress.

---
 rtl/blake2_ctrl_pkg.sv | 25 ++
 rtl/digest_serializer_rise_detect.sv | 18 +
 rtl/digest_serializer.sv | 107 ++++++++++
 tb/tb_digest_serializer.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/blake2_ctrl_pkg.sv
// blake2_ctrl_pkg: shared widths, readout FSM states and byte-reverse helper
package blake2_ctrl_pkg;

    localparam int DEFAULT_BUS_WIDTH    = 64;
    localparam int DEFAULT_DIGEST_WIDTH = 512;

    typedef enum logic {
        IDLE,
        SEND
    } ser_state_t;

    // Reverses the lowest nbytes bytes of v; byte 0 lands in the top byte of that span.
    function automatic logic [DEFAULT_DIGEST_WIDTH-1:0] byte_reverse(
        input logic [DEFAULT_DIGEST_WIDTH-1:0] v,
        input int                              nbytes
    );
        logic [DEFAULT_DIGEST_WIDTH-1:0] r;
        r = '0;
        for (int i = 0; i < DEFAULT_DIGEST_WIDTH / 8; i++)
            if (i < nbytes)
                r[8*(nbytes-1-i) +: 8] = v[8*i +: 8];
        return r;
    endfunction

endpackage

// File: rtl/digest_serializer_rise_detect.sv
// rise_detect: one-cycle pulse on the rising edge of a level input
module rise_detect (
    input  logic clk,
    input  logic reset_n,
    input  logic level,
    output logic rise
);

    logic level_q;

    // History of the level, updated every cycle unconditionally
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) level_q <= 1'b0;
        else          level_q <= level;

    assign rise = level && !level_q;

endmodule

// File: rtl/digest_serializer.sv
// digest_serializer: captures a Blake2 digest and streams it out as bus words
// Optional build macro DIGEST_BYTE_SWAP_EN byte-reverses every output word.
module digest_serializer
    import blake2_ctrl_pkg::*;
#(
    parameter int BUS_WIDTH    = DEFAULT_BUS_WIDTH,
    parameter int DIGEST_WIDTH = DEFAULT_DIGEST_WIDTH
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [DIGEST_WIDTH-1:0] digest,
    input  logic                    digest_valid,
    input  logic                    clear,
    output logic [BUS_WIDTH-1:0]    dout,
    output logic                    dout_valid,
    input  logic                    dout_ready,
    output logic                    dout_last,
    output logic                    busy,
    output logic                    overrun
);

    localparam int WORDS = DIGEST_WIDTH / BUS_WIDTH;
    localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WORDS - 1);

    if (DIGEST_WIDTH % BUS_WIDTH != 0) begin : g_bad_width
        $error("digest_serializer: BUS_WIDTH must divide DIGEST_WIDTH");
    end
`ifdef DIGEST_BYTE_SWAP_EN
    if (BUS_WIDTH % 8 != 0 || BUS_WIDTH > DEFAULT_DIGEST_WIDTH) begin : g_bad_swap
        $error("digest_serializer: byte swap needs BUS_WIDTH a multiple of 8");
    end
`endif

    ser_state_t              state, state_d;
    logic [IDX_W-1:0]        idx, idx_d;
    logic [DIGEST_WIDTH-1:0] shadow, shadow_d;
    logic                    ovr_d;
    logic                    rise;
    logic [BUS_WIDTH-1:0]    word, word_out;

    rise_detect u_rise (
        .clk     (clk),
        .reset_n (reset_n),
        .level   (digest_valid),
        .rise    (rise)
    );

    // Next state: clear wins, IDLE captures on rise, SEND advances on handshake
    always_comb begin
        state_d  = state;
        idx_d    = idx;
        shadow_d = shadow;
        ovr_d    = overrun;
        if (clear) begin
            state_d = IDLE;
            idx_d   = '0;
            ovr_d   = 1'b0;
        end else if (state == IDLE) begin
            if (rise) begin
                state_d  = SEND;
                idx_d    = '0;
                shadow_d = digest;
            end
        end else begin
            if (rise) ovr_d = 1'b1;
            if (dout_valid && dout_ready) begin
                state_d = (idx == IDX_LAST) ? IDLE : SEND;
                idx_d   = (idx == IDX_LAST) ? '0 : idx + 1'b1;
            end
        end
    end

    assign word = shadow_d[int'(idx_d)*BUS_WIDTH +: BUS_WIDTH];

`ifdef DIGEST_BYTE_SWAP_EN
    assign word_out = BUS_WIDTH'(byte_reverse(DEFAULT_DIGEST_WIDTH'(word), BUS_WIDTH / 8));
`else
    assign word_out = word;
`endif

    // FSM state register
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) state <= IDLE;
        else          state <= state_d;

    // Datapath and registered outputs, all derived from the next state
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            idx        <= '0;
            shadow     <= '0;
            overrun    <= 1'b0;
            dout       <= '0;
            dout_valid <= 1'b0;
            dout_last  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            idx        <= idx_d;
            shadow     <= shadow_d;
            overrun    <= ovr_d;
            dout       <= (state_d == SEND) ? word_out : '0;
            dout_valid <= state_d == SEND;
            dout_last  <= (state_d == SEND) && (idx_d == IDX_LAST);
            busy       <= state_d == SEND;
        end

endmodule

// File: tb/tb_digest_serializer.sv
// tb_digest_serializer: directed self-checking bench for digest_serializer
module tb_digest_serializer;

    localparam int BW = 64;
    localparam int DW = 512;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [DW-1:0] digest = '0;
    logic          digest_valid = 1'b0;
    logic          clear = 1'b0;
    logic [BW-1:0] dout;
    logic          dout_valid;
    logic          dout_ready = 1'b0;
    logic          dout_last;
    logic          busy;
    logic          overrun;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    digest_serializer #(.BUS_WIDTH(BW), .DIGEST_WIDTH(DW)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .digest       (digest),
        .digest_valid (digest_valid),
        .clear        (clear),
        .dout         (dout),
        .dout_valid   (dout_valid),
        .dout_ready   (dout_ready),
        .dout_last    (dout_last),
        .busy         (busy),
        .overrun      (overrun)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] pat(input logic [7:0] base);
        logic [DW-1:0] d;
        for (int i = 0; i < DW / 8; i++) d[8*i +: 8] = base + 8'(i);
        return d;
    endfunction

    function automatic logic [63:0] exp_word(input logic [7:0] base, input int k);
        logic [63:0] w;
        for (int j = 0; j < 8; j++)
`ifdef DIGEST_BYTE_SWAP_EN
            w[8*(7-j) +: 8] = base + 8'(8*k + j);
`else
            w[8*j +: 8] = base + 8'(8*k + j);
`endif
        return w;
    endfunction

    task automatic start(input logic [7:0] base);
        digest = pat(base);
        check("pre_valid", dout_valid, 0);
        digest_valid = 1'b1;
        tick();
        check("lat_valid", dout_valid, 1);
        check("lat_busy", busy, 1);
    endtask

    task automatic drain(input logic [7:0] base, input bit toggle, input int ovr_at);
        int n = 0;
        for (int c = 0; c < 40 && n < 8; c++) begin
            check("word", dout, exp_word(base, n));
            check("last", dout_last, n == 7);
            check("valid", dout_valid, 1);
            if (ovr_at >= 0) begin
                digest_valid = (n == ovr_at);
                if (n == ovr_at) digest = pat(8'h80);
            end
            dout_ready = toggle ? (c % 2 == 0) : 1'b1;
            if (dout_ready) n++;
            tick();
        end
        dout_ready = 1'b0;
        check("count", n, 8);
        check("busy_end", busy, 0);
        check("valid_end", dout_valid, 0);
        check("last_end", dout_last, 0);
    endtask

    initial begin
        int extra;
        #12;
        check("rst_dout", dout, 0);
        check("rst_valid", dout_valid, 0);
        check("rst_last", dout_last, 0);
        check("rst_busy", busy, 0);
        check("rst_overrun", overrun, 0);
        reset_n = 1'b1;
        tick();

        start(8'h00);
`ifdef DIGEST_BYTE_SWAP_EN
        check("w0_const", dout, 64'h0001020304050607);
`else
        check("w0_const", dout, 64'h0706050403020100);
`endif
        drain(8'h00, 1'b0, -1);
        digest_valid = 1'b0;
        tick();

        start(8'h00);
        digest_valid = 1'b0;
        drain(8'h00, 1'b1, -1);

        tick();
        start(8'h00);
        digest_valid = 1'b0;
        drain(8'h00, 1'b0, 3);
        check("ovr_set", overrun, 1);
        repeat (3) tick();
        check("ovr_no_busy", busy, 0);
        check("ovr_no_valid", dout_valid, 0);
        check("ovr_sticky", overrun, 1);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("ovr_cleared", overrun, 0);

        start(8'h00);
        digest_valid = 1'b0;
        dout_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check("clr_word", dout, exp_word(8'h00, k));
            digest_valid = (k == 1);
            tick();
        end
        check("clr_word4", dout, exp_word(8'h00, 4));
        check("clr_pre_ovr", overrun, 1);
        clear = 1'b1;
        digest_valid = 1'b1;
        digest = pat(8'h80);
        tick();
        clear = 1'b0;
        check("clr_busy", busy, 0);
        check("clr_valid", dout_valid, 0);
        check("clr_last", dout_last, 0);
        check("clr_overrun", overrun, 0);
        dout_ready = 1'b0;
        repeat (3) tick();
        check("clr_lost_valid", dout_valid, 0);
        check("clr_lost_busy", busy, 0);
        digest_valid = 1'b0;
        tick();

        start(8'h40);
        drain(8'h40, 1'b0, -1);
        extra = 0;
        for (int c = 0; c < 11; c++) begin
            if (dout_valid) extra++;
            tick();
        end
        check("one_readout", extra, 0);
        digest_valid = 1'b0;
        tick();

        start(8'h00);
        digest_valid = 1'b0;
        tick();
        digest_valid = 1'b1;
        tick();
        check("mid_valid", dout_valid, 1);
        check("mid_overrun", overrun, 1);
        check("mid_word", dout, exp_word(8'h00, 0));
        #3 reset_n = 1'b0;
        #1;
        check("arst_dout", dout, 0);
        check("arst_valid", dout_valid, 0);
        check("arst_last", dout_last, 0);
        check("arst_busy", busy, 0);
        check("arst_overrun", overrun, 0);
        digest_valid = 1'b0;
        #2 reset_n = 1'b1;
        tick();
        tick();
        check("post_valid", dout_valid, 0);
        check("post_busy", busy, 0);
        check("post_dout", dout, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
